// File: rtl/alu_exec_unit.sv
// Execution-stage ALU with valid/ready handshakes. Logic and arithmetic finish in one cycle.
// Shifts run one bit per cycle, so the result is late by Shamt cycles.
module alu_exec_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          ALU_Operation,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic [SHAMT_W-1:0]  Shamt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   Result,
  output logic                Zero,
  output logic                Overflow,
  output logic                Illegal
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_LUI = 4'b1101;
  localparam int         MSB    = DATA_W - 1;

  state_t               state_r, state_nxt_s;
  logic [DATA_W-1:0]    work_r, shift_nxt_s;
  logic [SHAMT_W-1:0]   cnt_r;
  logic [3:0]           op_r;
  logic [DATA_W-1:0]    result_r, alu_res_s, sum_s, diff_s;
  logic                 zero_r, ovf_r, illegal_r, out_valid_r;
  logic                 alu_ovf_s, alu_ill_s, is_shift_s, start_shift_s;

  assign sum_s         = A + B;
  assign diff_s        = A - B;
  assign is_shift_s    = (ALU_Operation == OP_SLL) || (ALU_Operation == OP_SRL) ||
                         (ALU_Operation == OP_SRA);
  assign start_shift_s = is_shift_s && (Shamt != {SHAMT_W{1'b0}});

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign Result    = result_r;
  assign Zero      = zero_r;
  assign Overflow  = ovf_r;
  assign Illegal   = illegal_r;

  // Single-cycle result for every op; a zero-distance shift simply passes B through.
  always_comb begin
    alu_res_s = {DATA_W{1'b0}};
    alu_ovf_s = 1'b0;
    alu_ill_s = 1'b0;
    case (ALU_Operation)
      OP_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = (A[MSB] == B[MSB]) && (sum_s[MSB] != A[MSB]);
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = (A[MSB] != B[MSB]) && (diff_s[MSB] != A[MSB]);
      end
      OP_AND:  alu_res_s = A & B;
      OP_OR:   alu_res_s = A | B;
      OP_XOR:  alu_res_s = A ^ B;
      OP_NOR:  alu_res_s = ~(A | B);
      OP_SLT:  alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL, OP_SRL, OP_SRA: alu_res_s = B;
      OP_LUI:  alu_res_s = {B[15:0], {(DATA_W-16){1'b0}}};
      default: alu_ill_s = 1'b1;
    endcase
  end

  // One-bit step of the latched shift.
  always_comb begin
    shift_nxt_s = {1'b0, work_r[MSB:1]};
    case (op_r)
      OP_SLL:  shift_nxt_s = {work_r[MSB-1:0], 1'b0};
      OP_SRA:  shift_nxt_s = {work_r[MSB], work_r[MSB:1]};
      default: shift_nxt_s = {1'b0, work_r[MSB:1]};
    endcase
  end

  // Next-state logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = start_shift_s ? SHIFT : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == SHAMT_W'(1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, shift iteration and registered result/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r      <= {DATA_W{1'b0}};
      cnt_r       <= {SHAMT_W{1'b0}};
      op_r        <= 4'b0000;
      result_r    <= {DATA_W{1'b0}};
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      illegal_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid && start_shift_s) begin
            work_r <= B;
            cnt_r  <= Shamt;
            op_r   <= ALU_Operation;
          end else if (in_valid) begin
            result_r  <= alu_res_s;
            zero_r    <= (alu_res_s == {DATA_W{1'b0}});
            ovf_r     <= alu_ovf_s;
            illegal_r <= alu_ill_s;
          end
        end
        SHIFT: begin
          work_r <= shift_nxt_s;
          cnt_r  <= cnt_r - SHAMT_W'(1);
          if (cnt_r == SHAMT_W'(1)) begin
            result_r  <= shift_nxt_s;
            zero_r    <= (shift_nxt_s == {DATA_W{1'b0}});
            ovf_r     <= 1'b0;
            illegal_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-stage ALU that consumes the 4-bit ALU_Operation code produced by the ALU control decoder, so it is the receiving end of that encoding.
- Performs logic and arithmetic in one cycle, and shifts iteratively at one bit per cycle.
- Uses a valid/ready handshake on both input and output, so the multi-cycle core can stall.

Parameters:
- DATA_W, 32, operand/result width (fixed at 32 for MIPS; shift logic assumes it)
- SHAMT_W, 5, shift-amount width (log2 DATA_W)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high only in IDLE
- ALU_Operation  in  4  op code, encoding below
- A  in  DATA_W  operand rs
- B  in  DATA_W  operand rt / immediate; source for shifts and lui
- Shamt  in  SHAMT_W  shift amount
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- Result  out  DATA_W  registered result
- Zero  out  1  Result == 0
- Overflow  out  1  signed overflow (add/sub only)
- Illegal  out  1  unsupported op code was executed

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_valid, Result, Zero, Overflow, Illegal = 0; shift counter = 0. in_ready=(state==IDLE), so it is 1 during and after reset. in_valid is ignored while rst_n is low.
- Op encoding (anything else is illegal):
  - 0010 add A+B
  - 0110 sub A-B
  - 0000 and
  - 0001 or
  - 0011 xor
  - 1100 nor
  - 0111 slt: signed A<B gives 1, else 0
  - 0100 sll B<<Shamt
  - 0101 srl B>>Shamt, zero fill
  - 1010 sra B>>>Shamt, sign fill
  - 1101 lui {B[15:0],16'h0}
- Accept rule: in_valid && in_ready at a rising edge. Operands and op are captured at that edge.
- States:
  - IDLE: accept a non-shift op, or a shift with Shamt==0 → compute, register outputs → DONE. Accept a shift with Shamt>0 → load work=B, cnt=Shamt, latch op → SHIFT.
  - SHIFT: each edge shift work one bit in the latched direction/fill and decrement cnt. On the edge where cnt goes 1→0, Result=work shifted, flags set → DONE. in_ready=0.
  - DONE: out_valid=1; Result and flags held stable. On out_valid && out_ready → IDLE, out_valid=0. in_ready=0, so back-to-back issue has one bubble.
- Latency:
  - non-shift, or Shamt==0: out_valid is high in the cycle after the accept cycle.
  - shift with Shamt=N>0: out_valid is high N cycles after that.
- Arithmetic:
  - add/sub use DATA_W-bit wrap-around.
  - Overflow=1 when both operands have the same sign and the result sign differs (add), or operand signs differ and the result sign differs from A (sub). Overflow=0 for all other ops.
  - Zero is computed from the final Result.
- Illegal code: completes with non-shift latency; Result=0, Zero=1, Overflow=0, Illegal=1. Illegal=0 for all legal ops.
- Reset mid-SHIFT or mid-DONE: operation aborted, no output produced, unit returns to IDLE.
- in_valid while busy: ignored, not queued. The requester must hold in_valid until in_ready.
- out_ready while not out_valid: no effect.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → out_valid=0, Result=0, Illegal=0, in_ready=1 immediately, without waiting for a clock edge.
- add A=0x7FFFFFFF B=1 → Result 0x80000000, Overflow=1, Zero=0, out_valid high in the cycle after accept. sub A=5 B=5 → Result 0, Zero=1, Overflow=0.
- slt A=0xFFFFFFFF B=1 → Result 1. lui B=0x00001234 → Result 0x12340000. nor A=0 B=0 → 0xFFFFFFFF.
- sra B=0x80000010 Shamt=4 → Result 0xF8000001, out_valid 4 cycles later than for add, in_ready=0 throughout. sll B=3 Shamt=0 → Result 3 with single-cycle latency. srl B=0x80000000 Shamt=31 → Result 1.
- Backpressure: hold out_ready=0 for 3 cycles after xor A=0xF0F0F0F0 B=0xFFFF0000 → Result 0x0F0FF0F0 stable, and a new in_valid is ignored. Raise out_ready → IDLE next cycle, in_ready=1.
- Illegal op 1111 → Result 0, Zero=1, Illegal=1. Reset asserted during a Shamt=20 sll → no out_valid; after release, a new add completes normally.
